// File: rtl/clap_sequence_counter.sv
// Clap sequence counter: synchronises a peak indication, debounces it with a
// refractory window and reports the number of claps once a silence gap expires.
module clap_sequence_counter #(
    parameter int COUNT_W     = 4,
    parameter int REFRACT_CYC = 5_000_000,
    parameter int GAP_CYC     = 50_000_000,
    parameter bit SATURATE    = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ledPeak,
    input  logic               clear,
    output logic [COUNT_W-1:0] clapCount,
    output logic [COUNT_W-1:0] seqCount,
    output logic               seqValid,
    output logic               busy
);

    localparam int MAX_CYC = (REFRACT_CYC > GAP_CYC) ? REFRACT_CYC : GAP_CYC;
    localparam int TIMER_W = $clog2(MAX_CYC + 1);
    localparam logic [TIMER_W-1:0] REFRACT_LAST = TIMER_W'(REFRACT_CYC - 1);
    localparam logic [TIMER_W-1:0] GAP_LAST     = TIMER_W'(GAP_CYC - 1);
    localparam logic [COUNT_W-1:0] COUNT_MAX    = {COUNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REFRACT = 2'd1,
        LISTEN  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [COUNT_W-1:0] clap_q, clap_d;
    logic [COUNT_W-1:0] seq_q, seq_d;
    logic               seq_valid_q, seq_valid_d;
    logic               busy_q, busy_d;
    logic               sync1_q, sync2_q, prev_q;
    logic               edge_s;

    // Next clap count in LISTEN: either pin at the maximum or roll over.
    function automatic logic [COUNT_W-1:0] clap_inc(input logic [COUNT_W-1:0] cnt);
        logic [COUNT_W-1:0] nxt;
        if (SATURATE && (cnt == COUNT_MAX)) begin
            nxt = cnt;
        end else begin
            nxt = cnt + COUNT_W'(1);
        end
        return nxt;
    endfunction

    assign edge_s = sync2_q & ~prev_q;

    // Synchroniser and edge history; reset high so a level held across reset is not a clap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= ledPeak;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // State, timer and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            clap_q      <= '0;
            seq_q       <= '0;
            seq_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            clap_q      <= clap_d;
            seq_q       <= seq_d;
            seq_valid_q <= seq_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic; clear overrides everything, and in LISTEN an edge beats the gap timeout.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        clap_d      = clap_q;
        seq_d       = seq_q;
        seq_valid_d = 1'b0;

        if (clear) begin
            state_d = IDLE;
            timer_d = '0;
            clap_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    timer_d = '0;
                    if (edge_s) begin
                        clap_d  = COUNT_W'(1);
                        state_d = REFRACT;
                    end else begin
                        clap_d  = clap_q;
                    end
                end
                REFRACT: begin
                    if (timer_q == REFRACT_LAST) begin
                        state_d = LISTEN;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
                LISTEN: begin
                    if (edge_s) begin
                        clap_d  = clap_inc(clap_q);
                        state_d = REFRACT;
                        timer_d = '0;
                    end else if (timer_q == GAP_LAST) begin
                        seq_d       = clap_q;
                        seq_valid_d = 1'b1;
                        clap_d      = '0;
                        state_d     = IDLE;
                        timer_d     = '0;
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    timer_d = '0;
                    clap_d  = '0;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    assign clapCount = clap_q;
    assign seqCount  = seq_q;
    assign seqValid  = seq_valid_q;
    assign busy      = busy_q;

endmodule
